// File: rtl/mem_io_bridge.sv
// CPU memory/IO bridge: RAM pass-through, UART TX FIFO and RX pop,
// free-running cycle counter with snapshot, sticky program-finish flag.
module mem_io_bridge #(
   parameter int TX_DEPTH    = 8,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic        ram_en,
   output logic        ram_wr,
   output logic [16:0] ram_a,
   output logic [7:0]  ram_dout,
   input  logic [7:0]  ram_din,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        program_finish
);

   localparam int PW = $clog2(TX_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      SRC_ZERO, SRC_RAM, SRC_RX, SRC_C0, SRC_C1, SRC_C2, SRC_C3
   } src_e;

   src_e          src_q, src_d;
   logic [31:0]   cnt_q, snap_q;
   logic [7:0]    rx_q;
   logic          pop_q, fin_q, bfull_q, bfull_d;
   logic [CW-1:0] cnt_tx_q, cnt_tx_d;
   logic [PW-1:0] wp_q, rp_q;
   logic [7:0]    fifo_q [TX_DEPTH];

   logic          is_io, rd_rx, snap_ld, push, fin_set, tx_pop, full, acc;
   logic [15:0]   off;
   logic [7:0]    push_data;
   logic          unused_hi;

   assign unused_hi = ^mem_a[31:18];
   assign is_io     = (mem_a[17:16] == 2'b11);
   assign off       = mem_a[15:0];

   assign ram_en   = ~is_io;
   assign ram_wr   = mem_wr & ~is_io;
   assign ram_a    = mem_a[16:0];
   assign ram_dout = mem_dout;

   assign rd_rx     = is_io & ~mem_wr & (off == 16'd0) & rx_valid;
   assign snap_ld   = is_io & ~mem_wr & (off == 16'd4);
   assign fin_set   = is_io & mem_wr & (off == 16'd4);
   assign push      = fin_set | (is_io & mem_wr & (off == 16'd0) & (mem_dout != 8'h00));
   assign push_data = fin_set ? 8'h00 : mem_dout;

   // A pop in the same cycle frees the slot, so a push at full is still taken
   assign tx_pop   = tx_valid & tx_ready;
   assign full     = (cnt_tx_q == CW'(TX_DEPTH));
   assign acc      = push & (~full | tx_pop);
   assign cnt_tx_d = cnt_tx_q + CW'(acc) - CW'(tx_pop);
   assign bfull_d  = ((CW'(TX_DEPTH) - cnt_tx_d) <= CW'(FULL_MARGIN));

   assign tx_valid       = (cnt_tx_q != '0);
   assign tx_data        = fifo_q[rp_q];
   assign io_buffer_full = bfull_q;
   assign rx_pop         = pop_q;
   assign program_finish = fin_q;

   always_comb begin
      src_d = SRC_ZERO;
      if (!mem_wr) begin
         if (!is_io) begin
            src_d = SRC_RAM;
         end else begin
            case (off)
               16'd0:   src_d = rx_valid ? SRC_RX : SRC_ZERO;
               16'd4:   src_d = SRC_C0;
               16'd5:   src_d = SRC_C1;
               16'd6:   src_d = SRC_C2;
               16'd7:   src_d = SRC_C3;
               default: src_d = SRC_ZERO;
            endcase
         end
      end
   end

   always_comb begin
      mem_din = 8'h00;
      case (src_q)
         SRC_RAM: mem_din = ram_din;
         SRC_RX:  mem_din = rx_q;
         SRC_C0:  mem_din = snap_q[7:0];
         SRC_C1:  mem_din = snap_q[15:8];
         SRC_C2:  mem_din = snap_q[23:16];
         SRC_C3:  mem_din = snap_q[31:24];
         default: mem_din = 8'h00;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         src_q    <= SRC_ZERO;
         cnt_q    <= '0;
         snap_q   <= '0;
         rx_q     <= '0;
         pop_q    <= 1'b0;
         fin_q    <= 1'b0;
         bfull_q  <= 1'b0;
         cnt_tx_q <= '0;
         wp_q     <= '0;
         rp_q     <= '0;
      end else begin
         src_q    <= src_d;
         cnt_q    <= cnt_q + 32'd1;
         pop_q    <= rd_rx;
         bfull_q  <= bfull_d;
         cnt_tx_q <= cnt_tx_d;
         wp_q     <= wp_q + PW'(acc);
         rp_q     <= rp_q + PW'(tx_pop);
         if (snap_ld) snap_q <= cnt_q;
         if (rd_rx)   rx_q   <= rx_data;
         if (fin_set) fin_q  <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible through the count
   always_ff @(posedge clk_in) begin
      if (acc) fifo_q[wp_q] <= push_data;
   end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: directed scenarios then
// randomized traffic against a queue/array reference model.
module tb_mem_io_bridge;

   localparam int DEPTH  = 8;
   localparam int MARGIN = 2;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [31:0] mem_a = '0;
   logic [7:0]  mem_dout = '0;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic        ram_en, ram_wr;
   logic [16:0] ram_a;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din = '0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_pop;
   logic        program_finish;

   int n_chk = 0;
   int n_fail = 0;

   mem_io_bridge #(.TX_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
      .mem_din(mem_din), .io_buffer_full(io_buffer_full),
      .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a),
      .ram_dout(ram_dout), .ram_din(ram_din),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
      .program_finish(program_finish)
   );

   always #5 clk_in = ~clk_in;

   // Synchronous RAM peripheral: read data valid one cycle after request
   bit [7:0] ram_m [bit [16:0]];
   always @(posedge clk_in) begin
      if (ram_en && ram_wr) ram_m[ram_a] = ram_dout;
      else if (ram_en) ram_din <= ram_m.exists(ram_a) ? ram_m[ram_a] : 8'h00;
   end

   // Reference model state
   logic [7:0]  q [$];
   bit [7:0]    exp_ram [bit [16:0]];
   logic [31:0] cyc_m;
   logic [31:0] snap_m;
   bit          fin_m, full_m;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      cyc_m  = 0;
      snap_m = 0;
      fin_m  = 0;
      full_m = 0;
   endtask

   task automatic chk_reset_outs();
      chk("rst_mem_din", mem_din, 8'h00);
      chk("rst_bfull", io_buffer_full, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_rx_pop", rx_pop, 0);
      chk("rst_finish", program_finish, 0);
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      #1;
      chk_reset_outs();
      repeat (2) @(posedge clk_in);
      #1;
      chk_reset_outs();
      rst_in = 1'b0;
      model_reset();
   endtask

   // One bus cycle; entered and left 1 time unit after a rising edge
   task automatic cyc(input logic [31:0] a, input logic [7:0] d,
                      input logic w, input logic rdy);
      bit          io, rd, pop, push, exp_pop;
      logic [15:0] off;
      logic [7:0]  exp_din, pdat;
      int          sz;
      mem_a = a; mem_dout = d; mem_wr = w; tx_ready = rdy;
      #1;
      io  = (a[17:16] == 2'b11);
      off = a[15:0];
      chk("ram_en", ram_en, !io);
      if (!io) begin
         chk("ram_a", ram_a, a[16:0]);
         chk("ram_wr", ram_wr, w);
         chk("ram_dout", ram_dout, d);
      end
      chk("tx_valid", tx_valid, q.size() != 0);
      if (q.size() != 0) chk("tx_data", tx_data, q[0]);
      rd = !w; exp_din = 8'h00; exp_pop = 0; push = 0; pdat = 8'h00;
      if (!io && !w) begin
         exp_din = exp_ram.exists(a[16:0]) ? exp_ram[a[16:0]] : 8'h00;
      end else if (!io) begin
         exp_ram[a[16:0]] = d;
      end else if (!w) begin
         if (off == 0) begin
            exp_din = rx_valid ? rx_data : 8'h00;
            exp_pop = rx_valid;
         end else if (off == 4) begin
            snap_m  = cyc_m;
            exp_din = snap_m[7:0];
         end else if (off == 5) exp_din = snap_m[15:8];
         else if (off == 6) exp_din = snap_m[23:16];
         else if (off == 7) exp_din = snap_m[31:24];
      end else begin
         if (off == 0 && d != 0) begin push = 1; pdat = d; end
         if (off == 4) begin push = 1; pdat = 8'h00; fin_m = 1; end
      end
      sz  = q.size();
      pop = (sz != 0) && rdy;
      if (pop) void'(q.pop_front());
      if (push && (sz < DEPTH || pop)) q.push_back(pdat);
      full_m = (DEPTH - q.size()) <= MARGIN;
      cyc_m  = cyc_m + 1;
      @(posedge clk_in);
      #1;
      if (rd) chk("mem_din", mem_din, exp_din);
      chk("rx_pop", rx_pop, exp_pop);
      chk("bfull", io_buffer_full, full_m);
      chk("finish", program_finish, fin_m);
   endtask

   task automatic idle(input logic rdy);
      cyc(32'h0003_0008, 8'h00, 1'b0, rdy);
   endtask

   initial begin
      logic [31:0] a;
      logic [7:0]  d;
      int          k;
      model_reset();
      #2;
      do_reset();

      // RAM write then read back, plus read of 0x00010 fed 0x5A
      cyc(32'h0000_0010, 8'h5A, 1'b1, 1'b0);
      cyc(32'h0000_0010, 8'h00, 1'b0, 1'b0);
      cyc(32'h0001_1234, 8'hC3, 1'b1, 1'b0);
      cyc(32'hFFF1_1234, 8'h00, 1'b0, 1'b0);

      // TX: 0x41, 0x00 (ignored), 0x42 then drain
      cyc(32'h0003_0000, 8'h41, 1'b1, 1'b0);
      cyc(32'h0003_0000, 8'h00, 1'b1, 1'b0);
      cyc(32'h0003_0000, 8'h42, 1'b1, 1'b0);
      repeat (4) idle(1'b1);

      // Fill past full: 9 writes with tx_ready low, then drain
      for (int i = 0; i < 9; i++)
         cyc(32'h0003_0000, 8'(8'h10 + i), 1'b1, 1'b0);
      // Push at full coincident with a pop
      cyc(32'h0003_0000, 8'hEE, 1'b1, 1'b1);
      repeat (10) idle(1'b1);

      // Counter snapshot at cycle 10 after reset
      do_reset();
      repeat (10) idle(1'b0);
      for (int i = 4; i < 8; i++)
         cyc(32'h0003_0000 | i, 8'h00, 1'b0, 1'b0);

      // RX read, then finish write and drain of its 0x00
      rx_valid = 1'b1; rx_data = 8'h37;
      cyc(32'h0003_0000, 8'h00, 1'b0, 1'b0);
      rx_valid = 1'b0;
      cyc(32'h0003_0000, 8'h00, 1'b0, 1'b0);
      cyc(32'h0003_0004, 8'h99, 1'b1, 1'b0);
      repeat (3) idle(1'b1);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         a = $urandom;
         d = 8'($urandom);
         rx_valid = ($urandom_range(0, 1) == 1);
         rx_data  = 8'($urandom);
         k = $urandom_range(0, 9);
         if (k < 4) begin
            a[17:16] = 2'($urandom_range(0, 2));
            a[15:0]  = 16'($urandom_range(0, 31));
         end else begin
            a[17:16] = 2'b11;
            case ($urandom_range(0, 5))
               0, 1:    a[15:0] = 16'd0;
               2:       a[15:0] = 16'($urandom_range(4, 7));
               3:       a[15:0] = (n % 50 == 0) ? 16'd4 : 16'd0;
               default: a[15:0] = 16'($urandom_range(0, 15));
            endcase
         end
         cyc(a, d, ($urandom_range(0, 2) == 0) || (k == 4),
             ($urandom_range(0, 2) == 0));
      end
      rx_valid = 1'b0;

      // Reset in the middle of a drain, then a normal read
      for (int i = 0; i < 5; i++)
         cyc(32'h0003_0000, 8'(8'h60 + i), 1'b1, 1'b0);
      cyc(32'h0000_0020, 8'hA5, 1'b1, 1'b1);
      cyc(32'h0003_0004, 8'h00, 1'b0, 1'b1);
      do_reset();
      exp_ram.delete();
      ram_m.delete();
      cyc(32'h0000_0021, 8'h7E, 1'b1, 1'b0);
      cyc(32'h0000_0021, 8'h00, 1'b0, 1'b0);
      cyc(32'h0003_0004, 8'h00, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8 (power of two, >=4): UART transmit FIFO depth in bytes.
REQ-002 SHALL have parameter FULL_MARGIN, default 2: free-slot threshold for io_buffer_full.
REQ-003 SHALL have ports: clk_in input 1, the single clock; rst_in input 1, asynchronous active-high reset.
REQ-004 SHALL have ports: mem_a input 32, CPU byte address (only [17:0] decoded); mem_dout input 8, CPU write data; mem_wr input 1, 1 = write, 0 = read.
REQ-005 SHALL have ports: mem_din output 8, read data to CPU; io_buffer_full output 1, TX FIFO nearly full.
REQ-006 SHALL have ports: ram_en output 1, ram_wr output 1, ram_a output 17, ram_dout output 8 (to RAM); ram_din input 8, RAM read data valid one cycle after the request.
REQ-007 SHALL have ports: tx_data output 8, tx_valid output 1, tx_ready input 1 (UART transmit handshake).
REQ-008 SHALL have ports: rx_data input 8, rx_valid input 1, rx_pop output 1 (UART receive byte consume pulse).
REQ-009 SHALL have port program_finish output 1, sticky stop indication.

Function
REQ-010 SHALL decode IO when mem_a[17:16]==2'b11, otherwise RAM.
REQ-011 RAM access SHALL be combinational: ram_en=1, ram_wr=mem_wr, ram_a=mem_a[16:0], ram_dout=mem_dout.
REQ-012 On any IO access, ram_en SHALL be 0.
REQ-013 Every read SHALL return data on mem_din exactly one cycle after the address cycle, selected by a registered source tag (RAM, RX, COUNTER byte 0..3, ZERO).
REQ-014 A 32-bit cycle counter SHALL increment every clock from 0 after reset, wrapping 0xFFFFFFFF -> 0.
REQ-015 A read of IO offset 4 SHALL latch the counter into a 32-bit snapshot; reads of offsets 4..7 SHALL return snapshot bytes 0..3 (little-endian) in the following cycle.
REQ-016 A read of IO offset 0 SHALL return rx_data and pulse rx_pop for one cycle when rx_valid=1; when rx_valid=0 it SHALL return 0x00 with no pop.
REQ-017 Reads of other IO offsets SHALL return 0x00.
REQ-018 A write of non-zero data to IO offset 0 SHALL enqueue mem_dout into the TX FIFO; a write of 0x00 to offset 0 SHALL be ignored.
REQ-019 Any write to IO offset 4 SHALL enqueue 0x00 and set program_finish; program_finish SHALL remain 1 until reset.
REQ-020 TX FIFO SHALL be a circular buffer with read/write pointers wrapping at TX_DEPTH and a count 0..TX_DEPTH.
REQ-021 tx_valid SHALL equal (count!=0); tx_data SHALL equal the head entry; a pop SHALL occur when tx_valid & tx_ready.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, including when count==TX_DEPTH (push accepted because pop frees the slot).
REQ-023 A push while full without simultaneous pop SHALL be dropped, with FIFO contents and pointers unchanged.
REQ-024 io_buffer_full SHALL be registered and equal 1 when TX_DEPTH - count <= FULL_MARGIN, evaluated on next-state count.
REQ-025 Pop while empty SHALL never occur (tx_valid=0).

Reset
REQ-026 While rst_in=1 asynchronously: counter=0, snapshot=0, FIFO count and pointers=0, source tag=ZERO, mem_din=0x00, io_buffer_full=0, tx_valid=0, rx_pop=0, program_finish=0.
REQ-027 Reset mid-transfer SHALL discard all FIFO contents and any pending read result; the first read after release SHALL behave normally.

Verification
REQ-028 RAM read: ram_din=0x5A returned for address 0x00010 -> mem_din=0x5A in the cycle after the request; ram_en=1, ram_a=0x00010 during the request.
REQ-029 TX: write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=0 -> count=2; then tx_ready=1 -> tx_data 0x41 then 0x42, tx_valid drops after 2 pops.
REQ-030 Full: TX_DEPTH=8, tx_ready=0, 6 writes -> io_buffer_full=1 after 6th; writes 7,8 accepted; 9th dropped; draining yields exactly 8 bytes in order.
REQ-031 Counter: reset released, read 0x30004..0x30007 on cycles 10..13 -> bytes of snapshot value taken at cycle 10 (0x0000000A), unaffected by counter advance.
REQ-032 Stop/RX: rx_valid=1, rx_data=0x37, read 0x30000 -> mem_din=0x37, rx_pop one pulse; write to 0x30004 -> program_finish=1 and 0x00 transmitted; assert rst_in mid-drain -> all outputs at REQ-026 values immediately.
